// File: rtl/hazard_flush_controller.sv
// hazard_flush_controller
//   Pipeline control for the 5-stage RISC-V core. It arbitrates three events:
//   data-memory wait states, taken-branch flushes resolved in EX, and load-use
//   stalls. It also keeps saturating statistics counters.
//   Control outputs are a combinational decode of (state, inputs). The FSM and
//   the counters are registered.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   id_rs1/id_rs2            source register indices of the instruction in ID
//   id_uses_rs1/id_uses_rs2  ID instruction actually reads that source
//   ex_mem_read, ex_rd       EX instruction is a load / its destination
//   ex_branch_taken          branch/jump in EX resolved taken
//   dmem_busy                data memory not ready this cycle
//   pc_write, if_id_write    write enables for PC and IF/ID
//   clear_if_id              load a NOP into IF/ID at the next edge
//   clear_pipeline           ID/EX emits a bubble at the next edge
//   pipe_hold                freeze all pipeline registers
//   flush_active             FSM is in FLUSH
//   stall_count              cycles with pc_write low (saturating)
//   flush_count              accepted taken branches (saturating)
module hazard_flush_controller #(
    parameter int reg_bits     = 5,
    parameter int flush_cycles = 2,
    parameter int cnt_bits     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [reg_bits-1:0] id_rs1,
    input  logic [reg_bits-1:0] id_rs2,
    input  logic                id_uses_rs1,
    input  logic                id_uses_rs2,
    input  logic                ex_mem_read,
    input  logic [reg_bits-1:0] ex_rd,
    input  logic                ex_branch_taken,
    input  logic                dmem_busy,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                clear_if_id,
    output logic                clear_pipeline,
    output logic                pipe_hold,
    output logic                flush_active,
    output logic [cnt_bits-1:0] stall_count,
    output logic [cnt_bits-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

    // fc counts the FLUSH cycles still to go after the branch cycle itself
    localparam logic [3:0] FC_INIT = 4'(flush_cycles - 1);

    state_t     state, state_nxt;
    logic [3:0] fc, fc_nxt;
    logic       lu;
    logic       flush_inc;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard
    assign lu = ex_mem_read && (ex_rd != '0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        clear_if_id    = 1'b0;
        clear_pipeline = 1'b0;
        pipe_hold      = 1'b0;
        flush_active   = 1'b0;
        state_nxt      = state;
        fc_nxt         = fc;
        flush_inc      = 1'b0;

        if (rst) begin
            pc_write       = 1'b0;
            if_id_write    = 1'b0;
            clear_if_id    = 1'b1;
            clear_pipeline = 1'b1;
            state_nxt      = RUN;
            fc_nxt         = '0;
        end else begin
            flush_active = (state == FLUSH);
            if (dmem_busy) begin
                // Memory wait freezes everything. A flush in progress keeps
                // its remaining count and resumes once memory releases.
                pipe_hold   = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                if (state != FLUSH)
                    state_nxt = MEM_WAIT;
            end else if (state == FLUSH) begin
                // The EX slot holds a bubble here, so branch and lu are moot
                clear_if_id    = 1'b1;
                clear_pipeline = 1'b1;
                fc_nxt         = 4'(fc - 4'd1);
                if (fc <= 4'd1)
                    state_nxt = RUN;
            end else begin
                // RUN and a released MEM_WAIT decode identically
                state_nxt = RUN;
                if (ex_branch_taken) begin
                    clear_if_id    = 1'b1;
                    clear_pipeline = 1'b1;
                    flush_inc      = 1'b1;
                    if (flush_cycles > 1) begin
                        state_nxt = FLUSH;
                        fc_nxt    = FC_INIT;
                    end
                end else if (lu) begin
                    pc_write       = 1'b0;
                    if_id_write    = 1'b0;
                    clear_pipeline = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            fc          <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state <= state_nxt;
            fc    <= fc_nxt;
            if (!pc_write && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
            if (flush_inc && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule
